vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 109 ++++++++++
 tb/tb_vga_scanout.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA raster scan-out: pixel/line counters, framebuffer read addressing and a
// registered colour/sync output stage, all advanced by a pixel-rate enable.
module vga_scanout #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [18:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [2:0]  fb_data,
  output logic [2:0]  vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        VGA_ready,
  output logic        frame_start
);

  localparam int unsigned CW       = 10;
  localparam int unsigned AW       = 19;
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG   = H_VIS + H_FP;
  localparam int unsigned HS_END   = H_VIS + H_FP + H_SYNC - 1;
  localparam int unsigned VS_BEG   = V_VIS + V_FP;
  localparam int unsigned VS_END   = V_VIS + V_FP + V_SYNC - 1;
  localparam int unsigned ADDR_MAX = H_VIS * V_VIS - 1;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [AW-1:0] r_fb_addr;
  logic          r_prev_vis;
  logic          r_rd_d;
  logic [2:0]    r_pix_data;
  logic [2:0]    r_rgb;
  logic          r_hs;
  logic          r_vs;
  logic          r_ready;
  logic          r_frame_start;

  logic          w_vis;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_frame_wrap;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;

  assign w_vis        = (r_h_cnt < CW'(H_VIS)) && (r_v_cnt < CW'(V_VIS));
  assign w_h_last     = (r_h_cnt == CW'(H_TOTAL - 1));
  assign w_v_last     = (r_v_cnt == CW'(V_TOTAL - 1));
  assign w_frame_wrap = pix_en && w_h_last && w_v_last;
  assign w_h_next     = w_h_last ? '0 : r_h_cnt + CW'(1);
  assign w_v_next     = !w_h_last ? r_v_cnt : (w_v_last ? '0 : r_v_cnt + CW'(1));

  // Gated by reset so no read strobe escapes while the scan is being aborted.
  assign fb_rd_en    = pix_en && w_vis && rst;
  assign fb_addr     = r_fb_addr;
  assign vga_rgb     = r_rgb;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign VGA_ready   = r_ready;
  assign frame_start = r_frame_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_fb_addr     <= '0;
      r_prev_vis    <= 1'b0;
      r_rd_d        <= 1'b0;
      r_pix_data    <= '0;
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_ready       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Read data returns one clk after the strobe; hold it for the next pixel tick.
      r_rd_d        <= fb_rd_en;
      r_frame_start <= w_frame_wrap;
      if (r_rd_d) begin
        r_pix_data <= fb_data;
      end
      if (pix_en) begin
        r_h_cnt    <= w_h_next;
        r_v_cnt    <= w_v_next;
        r_prev_vis <= w_vis;
        // Address saturates on the last visible pixel and holds until frame wrap.
        if (w_frame_wrap) begin
          r_fb_addr <= '0;
        end else if (w_vis && (r_fb_addr != AW'(ADDR_MAX))) begin
          r_fb_addr <= r_fb_addr + AW'(1);
        end
        r_rgb   <= r_prev_vis ? r_pix_data : 3'b000;
        r_hs    <= !((r_h_cnt >= CW'(HS_BEG)) && (r_h_cnt <= CW'(HS_END)));
        r_vs    <= !((r_v_cnt >= CW'(VS_BEG)) && (r_v_cnt <= CW'(VS_END)));
        r_ready <= (w_v_next >= CW'(V_VIS));
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a default-timing instance for line, stall and
// reset behaviour, and a miniature-timing instance for whole-frame behaviour.
module tb_vga_scanout;

  localparam int unsigned SH_VIS = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
  localparam int unsigned SV_VIS = 6, SV_FP = 1, SV_SYNC = 2, SV_BP = 2;
  localparam int unsigned SH_TOT = 16;
  localparam int unsigned SF_TOT = 176;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, pe_a = 1'b0;
  logic [18:0] addr_a;
  logic        rd_a;
  logic [2:0]  data_a = 3'd0, rgb_a;
  logic        hs_a, vs_a, rdy_a, fs_a;

  logic        rst_b = 1'b1, pe_b = 1'b0;
  logic [18:0] addr_b;
  logic        rd_b;
  logic [2:0]  data_b = 3'd0, rgb_b;
  logic        hs_b, vs_b, rdy_b, fs_b;

  vga_scanout dut_a (
    .clk(clk), .rst(rst_a), .pix_en(pe_a), .fb_addr(addr_a), .fb_rd_en(rd_a),
    .fb_data(data_a), .vga_rgb(rgb_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .VGA_ready(rdy_a), .frame_start(fs_a)
  );

  vga_scanout #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(pe_b), .fb_addr(addr_b), .fb_rd_en(rd_b),
    .fb_data(data_b), .vga_rgb(rgb_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .VGA_ready(rdy_b), .frame_start(fs_b)
  );

  // Framebuffer model: content is the low address bits, one clk read latency.
  always @(posedge clk) begin
    if (rd_a) data_a <= addr_a[2:0];
    if (rd_b) data_b <= addr_b[2:0];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel tick on instance A, pix_en period of 4 clks.
  task automatic tick_a(output logic rd, output logic [18:0] a);
    @(negedge clk); pe_a = 1'b1; #1;
    rd = rd_a; a = addr_a;
    @(negedge clk); pe_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One pixel tick on instance B, pix_en period of 2 clks.
  task automatic tick_b(output logic rd, output logic [18:0] a);
    @(negedge clk); pe_b = 1'b1; #1;
    rd = rd_b; a = addr_b;
    @(negedge clk); pe_b = 1'b0;
  endtask

  logic        rd;
  logic [18:0] a;
  logic [2:0]  exp_rgb;
  int rd_cnt, seq_err, hs_low, hs_first, rgb_err;
  int vs_low, rdy_hi, fs_cnt, fs_first, fs_second, last_rd;
  int p, h, v, pa, prev_addr;
  logic vis, prev_vis;

  initial begin
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_addr",  32'(addr_a), 0);
    chk("rst_rgb",   32'(rgb_a), 0);
    chk("rst_hs",    32'(hs_a), 1);
    chk("rst_vs",    32'(vs_a), 1);
    chk("rst_ready", 32'(rdy_a), 0);
    chk("rst_fs",    32'(fs_a), 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Line 0 at default timing.
    rd_cnt = 0; seq_err = 0; hs_low = 0; hs_first = -1; rgb_err = 0;
    for (int i = 0; i < 800; i++) begin
      tick_a(rd, a);
      if (rd) begin
        rd_cnt++;
        if (i >= 640 || a != 19'(i)) seq_err++;
      end else if (i < 640) seq_err++;
      if (!hs_a) begin
        if (hs_low == 0) hs_first = i;
        hs_low++;
      end
      exp_rgb = (i >= 1 && i <= 640) ? 3'(i - 1) : 3'd0;
      if (rgb_a !== exp_rgb) rgb_err++;
    end
    chk("line_reads",    32'(rd_cnt), 640);
    chk("line_addr_seq", 32'(seq_err), 0);
    chk("hs_low_len",    32'(hs_low), 96);
    chk("hs_first_tick", 32'(hs_first), 656);
    chk("line_rgb",      32'(rgb_err), 0);
    chk("line_vs",       32'(vs_a), 1);
    chk("line_ready",    32'(rdy_a), 0);
    chk("addr_line1",    32'(addr_a), 640);

    // Stall mid-line 1 at h=100.
    for (int i = 0; i < 100; i++) tick_a(rd, a);
    repeat (50) @(negedge clk);
    chk("stall_addr", 32'(addr_a), 740);
    chk("stall_rgb",  32'(rgb_a), 2);
    chk("stall_hs",   32'(hs_a), 1);
    chk("stall_h",    32'(dut_a.r_h_cnt), 100);
    chk("stall_v",    32'(dut_a.r_v_cnt), 1);
    tick_a(rd, a);
    chk("resume_rd",   32'(rd), 1);
    chk("resume_addr", 32'(a), 740);
    chk("resume_rgb",  32'(rgb_a), 3);

    // Asynchronous reset mid-line with pix_en high.
    for (int i = 0; i < 199; i++) tick_a(rd, a);
    chk("pre_rst_h", 32'(dut_a.r_h_cnt), 300);
    @(negedge clk); pe_a = 1'b1; #1;
    rst_a = 1'b0; #1;
    chk("arst_addr",  32'(addr_a), 0);
    chk("arst_rgb",   32'(rgb_a), 0);
    chk("arst_rd",    32'(rd_a), 0);
    chk("arst_hs",    32'(hs_a), 1);
    chk("arst_vs",    32'(vs_a), 1);
    chk("arst_ready", 32'(rdy_a), 0);
    chk("arst_h",     32'(dut_a.r_h_cnt), 0);
    chk("arst_v",     32'(dut_a.r_v_cnt), 0);
    pe_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    tick_a(rd, a);
    chk("post_rst_rd",   32'(rd), 1);
    chk("post_rst_addr", 32'(a), 0);

    // Two full frames on the miniature instance.
    rd_cnt = 0; seq_err = 0; rgb_err = 0; hs_low = 0; vs_low = 0; rdy_hi = 0;
    fs_cnt = 0; fs_first = -1; fs_second = -1; last_rd = -1;
    prev_vis = 1'b0; prev_addr = 0;
    for (int g = 0; g < 2 * SF_TOT; g++) begin
      p = g % SF_TOT; h = p % SH_TOT; v = p / SH_TOT;
      vis = (h < SH_VIS) && (v < SV_VIS);
      pa = v * SH_VIS + h;
      tick_b(rd, a);
      if (rd !== vis) seq_err++;
      if (rd) begin
        if (g < SF_TOT) begin rd_cnt++; last_rd = 32'(a); end
        if (a != 19'(pa)) seq_err++;
      end
      exp_rgb = prev_vis ? 3'(prev_addr) : 3'd0;
      if (rgb_b !== exp_rgb) rgb_err++;
      prev_vis = vis; prev_addr = pa;
      if (g < SF_TOT) begin
        if (!hs_b) hs_low++;
        if (!vs_b) vs_low++;
        if (rdy_b) rdy_hi++;
      end
      if (fs_b) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = g; else fs_second = g;
      end
      if (g == SF_TOT - 2) chk("addr_hold_max", 32'(addr_b), 47);
      if (g == SF_TOT - 1) begin
        chk("wrap_h",     32'(dut_b.r_h_cnt), 0);
        chk("wrap_v",     32'(dut_b.r_v_cnt), 0);
        chk("wrap_addr",  32'(addr_b), 0);
        chk("wrap_fs",    32'(fs_b), 1);
        chk("wrap_ready", 32'(rdy_b), 0);
        @(negedge clk);
        chk("fs_one_clk", 32'(fs_b), 0);
      end
    end
    chk("frame_reads",    32'(rd_cnt), 48);
    chk("frame_last_rd",  32'(last_rd), 47);
    chk("frame_addr_seq", 32'(seq_err), 0);
    chk("frame_rgb",      32'(rgb_err), 0);
    chk("frame_hs_low",   32'(hs_low), 33);
    chk("frame_vs_low",   32'(vs_low), 32);
    chk("frame_ready_hi", 32'(rdy_hi), 80);
    chk("fs_count",       32'(fs_cnt), 2);
    chk("fs_period",      32'(fs_second - fs_first), SF_TOT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
